// File: rtl/pot_sched.sv
// Round-robin scheduler that reads six potentiometers through an A2D on an SPI master.
// Each channel takes two identical transactions; the second result is stored.
module pot_sched #(
    parameter int GAP_CYCLES = 1024,
    parameter int TIMEOUT    = 4095
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    input  logic        spi_done,
    input  logic [15:0] spi_rd,
    output logic        spi_wrt,
    output logic [15:0] spi_cmd,
    output logic [11:0] lp_pot,
    output logic [11:0] b1_pot,
    output logic [11:0] b2_pot,
    output logic [11:0] b3_pot,
    output logic [11:0] hp_pot,
    output logic [11:0] vol_pot,
    output logic        chnl_upd,
    output logic [2:0]  upd_idx,
    output logic        round_done,
    output logic        err
);

    localparam int GW = (GAP_CYCLES < 2) ? 1 : $clog2(GAP_CYCLES);
    localparam int TW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);
    localparam logic [GW-1:0] GAP_LAST = GW'(GAP_CYCLES - 1);
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        GAP   = 3'd1,
        TX1   = 3'd2,
        WT1   = 3'd3,
        TX2   = 3'd4,
        WT2   = 3'd5,
        STORE = 3'd6
    } state_t;

    state_t          state_r;
    logic [2:0]      idx_r;
    logic [GW-1:0]   gap_cnt_r;
    logic [TW-1:0]   tmo_cnt_r;
    logic [11:0]     pot_r [0:5];

    // Round slot to A2D channel mapping, packed into the command word.
    function automatic logic [15:0] cmd_of(input logic [2:0] idx);
        logic [2:0] ch;
        case (idx)
            3'd0:    ch = 3'd1;
            3'd1:    ch = 3'd0;
            3'd2:    ch = 3'd4;
            3'd3:    ch = 3'd2;
            3'd4:    ch = 3'd3;
            3'd5:    ch = 3'd7;
            default: ch = 3'd0;
        endcase
        return {2'b00, ch, 11'h000};
    endfunction

    assign lp_pot  = pot_r[0];
    assign b1_pot  = pot_r[1];
    assign b2_pot  = pot_r[2];
    assign b3_pot  = pot_r[3];
    assign hp_pot  = pot_r[4];
    assign vol_pot = pot_r[5];

    // Scheduler FSM with all outputs registered; pulses default low every cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r    <= IDLE;
            idx_r      <= 3'd0;
            gap_cnt_r  <= '0;
            tmo_cnt_r  <= '0;
            spi_wrt    <= 1'b0;
            spi_cmd    <= 16'h0000;
            chnl_upd   <= 1'b0;
            upd_idx    <= 3'd0;
            round_done <= 1'b0;
            err        <= 1'b0;
            for (int i = 0; i < 6; i++) begin
                pot_r[i] <= 12'h000;
            end
        end else begin
            spi_wrt    <= 1'b0;
            chnl_upd   <= 1'b0;
            round_done <= 1'b0;
            case (state_r)
                IDLE: begin
                    if (en) begin
                        state_r <= TX1;
                        spi_wrt <= 1'b1;
                        spi_cmd <= cmd_of(idx_r);
                    end else begin
                        spi_cmd <= 16'h0000;
                    end
                end
                GAP: begin
                    if (gap_cnt_r == GAP_LAST) begin
                        gap_cnt_r <= '0;
                        if (en) begin
                            state_r <= TX1;
                            spi_wrt <= 1'b1;
                            spi_cmd <= cmd_of(idx_r);
                        end else begin
                            state_r <= IDLE;
                            spi_cmd <= 16'h0000;
                        end
                    end else begin
                        gap_cnt_r <= gap_cnt_r + 1'b1;
                    end
                end
                TX1: begin
                    state_r   <= WT1;
                    tmo_cnt_r <= '0;
                end
                WT1: begin
                    if (spi_done) begin
                        state_r   <= TX2;
                        spi_wrt   <= 1'b1;
                        tmo_cnt_r <= '0;
                    end else if (tmo_cnt_r == TMO_LAST) begin
                        // Abandon the channel: no update, but the round still advances.
                        err        <= 1'b1;
                        state_r    <= STORE;
                        round_done <= (idx_r == 3'd5);
                        tmo_cnt_r  <= '0;
                    end else begin
                        tmo_cnt_r <= tmo_cnt_r + 1'b1;
                    end
                end
                TX2: begin
                    state_r   <= WT2;
                    tmo_cnt_r <= '0;
                end
                WT2: begin
                    if (spi_done) begin
                        pot_r[idx_r] <= spi_rd[11:0];
                        chnl_upd     <= 1'b1;
                        upd_idx      <= idx_r;
                        round_done   <= (idx_r == 3'd5);
                        state_r      <= STORE;
                        tmo_cnt_r    <= '0;
                    end else if (tmo_cnt_r == TMO_LAST) begin
                        err        <= 1'b1;
                        state_r    <= STORE;
                        round_done <= (idx_r == 3'd5);
                        tmo_cnt_r  <= '0;
                    end else begin
                        tmo_cnt_r <= tmo_cnt_r + 1'b1;
                    end
                end
                STORE: begin
                    if (idx_r == 3'd5) begin
                        idx_r     <= 3'd0;
                        state_r   <= GAP;
                        gap_cnt_r <= '0;
                        spi_cmd   <= 16'h0000;
                    end else if (en) begin
                        idx_r   <= idx_r + 3'd1;
                        state_r <= TX1;
                        spi_wrt <= 1'b1;
                        spi_cmd <= cmd_of(idx_r + 3'd1);
                    end else begin
                        idx_r   <= idx_r + 3'd1;
                        state_r <= IDLE;
                        spi_cmd <= 16'h0000;
                    end
                end
                default: begin
                    state_r <= IDLE;
                    spi_cmd <= 16'h0000;
                end
            endcase
        end
    end

endmodule
